// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared widths, defaults, state type and helpers for the VRAM arbiter
//
// Purpose : common definitions imported by vram_arbiter and rr_pick.
// Contents: ADDR_W / DATA_W bus widths, default NREQ / RD_LAT, the
//           arbiter state enum, and a one-hot to index helper.
package vram_pkg;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 8;
    localparam int NREQ_DEF   = 3;
    localparam int RD_LAT_DEF = 1;

    // Requester indices are carried in a fixed 2-bit field so that every
    // NREQ in 2..4 shares the same index width.
    localparam int MAX_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RDWAIT = 2'd2
    } state_t;

    function automatic logic [IDX_W-1:0] oh2idx(input logic [MAX_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/vram_arbiter_rr_pick.sv
// rtl/vram_arbiter_rr_pick.sv - combinational round-robin picker
//
// Purpose : pick the first set request at or after the pointer, wrapping.
// Ports   : i_req   [NREQ-1:0] request vector
//           i_ptr   [IDX_W-1:0] index searched first
//           o_gnt   [NREQ-1:0] one-hot winner (zero when nothing requests)
//           o_valid            at least one request is set
module rr_pick
    import vram_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_gnt,
    output logic             o_valid
);

    // Requests and grants are padded to MAX_REQ so a fixed-width index can
    // address them for every NREQ.
    logic [MAX_REQ-1:0] w_req_pad;
    logic [MAX_REQ-1:0] w_gnt_pad;
    logic [IDX_W:0]     w_sum;
    logic               w_found;

    assign w_req_pad = MAX_REQ'(i_req);

    always_comb begin
        w_gnt_pad = '0;
        w_found   = 1'b0;
        w_sum     = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(NREQ)) begin
                w_sum = w_sum - (IDX_W+1)'(NREQ);
            end
            if (!w_found && w_req_pad[w_sum[IDX_W-1:0]]) begin
                w_gnt_pad[w_sum[IDX_W-1:0]] = 1'b1;
                w_found                     = 1'b1;
            end
        end
    end

    assign o_gnt   = w_gnt_pad[NREQ-1:0];
    assign o_valid = |i_req;

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - multi-requester VRAM access arbiter
//
// Purpose : serialises requester accesses onto one memory port. Writes run
//           one per clock; reads wait RD_LAT edges for din and return it
//           with a one-hot rvalid pulse. During vsync requester 0 wins.
// Ports   : clk, reset (async, active high), vsync
//           req / we [NREQ], req_addr [NREQ][16], req_wdata [NREQ][8]
//           gnt / rvalid [NREQ] one-hot pulses, rdata [8]
//           addr [16], data [8], rw (memory side), din [8]
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          vsync,
    input  logic [NREQ-1:0]               req,
    input  logic [NREQ-1:0]               we,
    input  logic [NREQ-1:0][ADDR_W-1:0]   req_addr,
    input  logic [NREQ-1:0][DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]               gnt,
    output logic [NREQ-1:0]               rvalid,
    output logic [DATA_W-1:0]             rdata,
    output logic [ADDR_W-1:0]             addr,
    output logic [DATA_W-1:0]             data,
    input  logic [DATA_W-1:0]             din,
    output logic                          rw
);

    state_t             r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_win;
    logic [1:0]         r_lat_cnt;
    logic [NREQ-1:0]    r_gnt;
    logic [NREQ-1:0]    r_rvalid;
    logic [DATA_W-1:0]  r_rdata;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_data;
    logic               r_rw;

    logic               w_read_done;
    logic               w_sel_en;
    logic [MAX_REQ-1:0] w_win_oh;
    logic [NREQ-1:0]    w_mask;
    logic [NREQ-1:0]    w_req_m;
    logic               w_vs_pri;
    logic [NREQ-1:0]    w_rr_gnt;
    logic               w_any;
    logic [NREQ-1:0]    w_pick;
    logic [IDX_W-1:0]   w_pick_idx;
    logic [IDX_W-1:0]   w_ptr_next;
    logic               w_grant;

    // This edge samples din: RD_LAT edges after the read's ACCESS cycle began.
    assign w_read_done = (r_state == ST_ACCESS && !r_rw && RD_LAT == 1) ||
                         (r_state == ST_RDWAIT && (r_lat_cnt + 2'd1) == 2'(RD_LAT));

    // A new selection may happen from IDLE, after a write, or on the read's
    // data-return edge (so the next grant lands in the rvalid cycle).
    assign w_sel_en = (r_state == ST_IDLE) ||
                      (r_state == ST_ACCESS && r_rw) ||
                      w_read_done;

    // The reader whose data is returning is excluded so its gnt can never
    // coincide with its own rvalid.
    assign w_win_oh = MAX_REQ'(1) << r_win;
    assign w_mask   = w_read_done ? ~w_win_oh[NREQ-1:0] : '1;
    assign w_req_m  = req & w_mask;

    assign w_vs_pri = vsync & w_req_m[0];

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .i_req   (w_req_m),
        .i_ptr   (r_ptr),
        .o_gnt   (w_rr_gnt),
        .o_valid (w_any)
    );

    assign w_pick     = w_vs_pri ? NREQ'(1) : w_rr_gnt;
    assign w_pick_idx = oh2idx(MAX_REQ'(w_pick));
    assign w_ptr_next = (w_pick_idx == IDX_W'(NREQ - 1)) ? '0 : w_pick_idx + 1'b1;
    assign w_grant    = w_sel_en & w_any;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_win     <= '0;
            r_lat_cnt <= '0;
            r_gnt     <= '0;
            r_rvalid  <= '0;
            r_rdata   <= '0;
            r_addr    <= '0;
            r_data    <= '0;
            r_rw      <= 1'b0;
        end else begin
            r_gnt    <= '0;
            r_rw     <= 1'b0;
            r_rvalid <= '0;

            if (w_read_done) begin
                r_rvalid <= w_win_oh[NREQ-1:0];
                r_rdata  <= din;
            end

            if (w_grant) begin
                r_state <= ST_ACCESS;
                r_win   <= w_pick_idx;
                r_gnt   <= w_pick;
                r_rw    <= we[w_pick_idx];
                r_addr  <= req_addr[w_pick_idx];
                r_data  <= req_wdata[w_pick_idx];
                // vsync-priority grants leave the round-robin position alone
                if (!w_vs_pri) begin
                    r_ptr <= w_ptr_next;
                end
            end else if (r_state == ST_ACCESS && !r_rw && RD_LAT > 1) begin
                r_state   <= ST_RDWAIT;
                r_lat_cnt <= 2'd1;
            end else if (r_state == ST_RDWAIT && !w_read_done) begin
                r_lat_cnt <= r_lat_cnt + 2'd1;
            end else begin
                r_state <= ST_IDLE;
            end
        end
    end

    assign gnt    = r_gnt;
    assign rvalid = r_rvalid;
    assign rdata  = r_rdata;
    assign addr   = r_addr;
    assign data   = r_data;
    assign rw     = r_rw;

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 3: number of requesters, 2..4.
REQ-002 The block SHALL have parameter RD_LAT, default 1: memory read latency in clocks, 1..3.
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 The block SHALL have port vsync, input, 1: high means the vertical-blank window.
REQ-006 The block SHALL have port req, input, NREQ: per-requester access request, level.
REQ-007 The block SHALL have port we, input, NREQ: per-requester write enable (1=write, 0=read).
REQ-008 The block SHALL have port req_addr, input, NREQ x 16: per-requester address.
REQ-009 The block SHALL have port req_wdata, input, NREQ x 8: per-requester write data.
REQ-010 The block SHALL have port gnt, output, NREQ: one-hot, one-cycle pulse marking the cycle an access is on the bus.
REQ-011 The block SHALL have port rvalid, output, NREQ: one-hot, one-cycle pulse marking read data returned.
REQ-012 The block SHALL have port rdata, output, 8: read data, valid while any rvalid bit is high.
REQ-013 The block SHALL have port addr, output, 16: memory address.
REQ-014 The block SHALL have port data, output, 8: memory write data.
REQ-015 The block SHALL have port din, input, 8: memory read data.
REQ-016 The block SHALL have port rw, output, 1: memory strobe (1=write, 0=read or idle).

Function
REQ-017 The block SHALL use states IDLE, ACCESS and RDWAIT, all registered.
REQ-018 IDLE/ACCESS transition: on each edge where any req is high, the block SHALL register the winner, enter ACCESS, and drive addr/data/rw/gnt from the winner's inputs in the following cycle.
REQ-019 Winner selection while vsync=1: requester 0 SHALL have absolute priority.
REQ-020 Winner selection otherwise: selection SHALL be round-robin, starting at the index after the last granted one, wrapping from NREQ-1 to 0.
REQ-021 Write accesses: rw SHALL be 1 for exactly the ACCESS cycle, and the next grant SHALL follow back-to-back when requests are pending (1 access/clock).
REQ-022 Read accesses: rw SHALL be 0, and the state SHALL go to RDWAIT. din SHALL be sampled RD_LAT edges after the ACCESS cycle begins. rdata and rvalid[winner] SHALL be registered from that edge. No new grant SHALL be issued until the rvalid cycle.
REQ-023 Requesters SHALL hold req, we, req_addr and req_wdata stable until gnt. A requester dropping req before the sampling edge SHALL NOT be granted.
REQ-024 When not in ACCESS, the block SHALL drive rw=0 and gnt=0, and addr and data SHALL hold their last values.
REQ-025 A vsync edge during ACCESS or RDWAIT SHALL NOT abort the access; priority changes SHALL apply at the next selection only.
REQ-026 The round-robin pointer SHALL update only on a grant, and SHALL NOT update on vsync-priority grants to requester 0.
REQ-027 gnt and rvalid SHALL never have more than one bit set; rvalid SHALL NOT coincide with a gnt to the same index.

Reset
REQ-028 On reset assertion, the block SHALL immediately set state=IDLE, pointer=0, gnt=0, rvalid=0, rdata=0, addr=0, data=0 and rw=0.
REQ-029 A read in flight at reset SHALL be discarded without any rvalid pulse.
REQ-030 On reset release, the first selection SHALL occur on the first clock edge after release.

Structure
REQ-031 Package vram_pkg SHALL hold ADDR_W=16, DATA_W=8, the state enum, and the default NREQ and RD_LAT values.
REQ-032 Sub-module rr_pick SHALL be purely combinational: inputs req vector and pointer, output one-hot grant and a valid flag.
REQ-033 The implementation SHALL be 120-400 lines of RTL in total.

Verification
REQ-034 Scenario (lone writer): req[1]=1, we=1, addr 16'hF005, wdata 8'h41 -> next cycle gnt[1]=1, addr=F005, data=41, rw=1.
REQ-035 Scenario (all requesters, vsync=0): req=3'b111 all writes for 6 cycles -> gnt sequence 0,1,2,0,1,2.
REQ-036 Scenario (vsync priority): vsync=1, req=3'b111 -> gnt[0] every cycle; after vsync drops, round-robin resumes from the saved pointer.
REQ-037 Scenario (read): RD_LAT=2, read addr 16'h0000, din=8'h5A -> rvalid pulses 2 cycles after gnt with rdata=5A, and no grant occurs in between.
REQ-038 Scenario (reset mid-read): reset asserted during RDWAIT -> outputs zero immediately, and no rvalid pulse after release.
REQ-039 Scenario (request drop): req[2] deasserted before the sampling edge -> gnt[2] never asserted.
